// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared types and helpers for the multi-channel debouncer:
//               hold-state encoding and the counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Per-channel hold tracking: released, pressed, pressed past the long mark
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HELD      = 2'd1,
        LONG_DONE = 2'd2
    } holdState_t;

    // Number of bits needed to hold every value from 0 up to maxValue
    function automatic int cntWidth(input int unsigned maxValue);
        int w;
        w = 1;
        while ((longint'(1) << w) <= longint'(maxValue)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One button channel: input synchroniser, stable-level
//               counter, debounced level with press/release pulses, and
//               a hold FSM that emits a single long-press pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btnIn,
    output logic btnOut,
    output logic btnPress,
    output logic btnRelease,
    output logic btnLong
);

    localparam int c_stableW = cntWidth(DEBOUNCE_CYCLES);
    localparam int c_holdW   = cntWidth(LONG_CYCLES);

    localparam logic [c_stableW-1:0] c_stableLast = c_stableW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_stableW-1:0] c_stableOne  = c_stableW'(1);
    localparam logic [c_holdW-1:0]   c_holdLast   = c_holdW'(LONG_CYCLES - 1);
    localparam logic [c_holdW-1:0]   c_holdMax    = {c_holdW{1'b1}};
    localparam logic [c_holdW-1:0]   c_holdOne    = c_holdW'(1);

    logic [SYNC_STAGES-1:0] r_syncChain;
    logic [c_stableW-1:0]   r_stableCnt;
    logic [c_holdW-1:0]     r_holdCnt;
    logic                   r_btnOut;
    logic                   r_btnPress;
    logic                   r_btnRelease;
    logic                   r_btnLong;
    holdState_t             r_state;
    holdState_t             w_stateNext;
    logic                   w_longNext;
    logic                   w_sync;
    logic                   w_differ;
    logic                   w_accept;
    logic                   w_rise;
    logic                   w_fall;

    // Shift the raw asynchronous level through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_syncChain <= '0;
        end else begin
            r_syncChain <= {r_syncChain[SYNC_STAGES-2:0], btnIn};
        end
    end

    assign w_sync   = r_syncChain[SYNC_STAGES-1];
    assign w_differ = (w_sync != r_btnOut);
    // The level change is accepted on the edge that would complete the run
    assign w_accept = w_differ && (r_stableCnt == c_stableLast);
    assign w_rise   = w_accept && !r_btnOut;
    assign w_fall   = w_accept && r_btnOut;

    // Count consecutive cycles the synchronised level disagrees with the output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stableCnt <= '0;
        end else if (!w_differ || w_accept) begin
            r_stableCnt <= '0;
        end else begin
            r_stableCnt <= r_stableCnt + c_stableOne;
        end
    end

    // Debounced level plus edge pulses, all updated on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btnOut     <= 1'b0;
            r_btnPress   <= 1'b0;
            r_btnRelease <= 1'b0;
        end else begin
            r_btnPress   <= w_rise;
            r_btnRelease <= w_fall;
            if (w_accept) begin
                r_btnOut <= ~r_btnOut;
            end
        end
    end

    // Hold FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Hold FSM transitions; the long pulse is requested on the HELD exit only
    always_comb begin
        w_stateNext = r_state;
        w_longNext  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_stateNext = HELD;
                end
            end
            HELD: begin
                if (w_fall) begin
                    w_stateNext = IDLE;
                end else if (r_holdCnt == c_holdLast) begin
                    w_stateNext = LONG_DONE;
                    w_longNext  = 1'b1;
                end
            end
            LONG_DONE: begin
                if (w_fall) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Hold counter runs only while HELD; held at zero otherwise so entry starts clean
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_holdCnt <= '0;
        end else if (r_state != HELD) begin
            r_holdCnt <= '0;
        end else if (r_holdCnt != c_holdMax) begin
            r_holdCnt <= r_holdCnt + c_holdOne;
        end
    end

    // Register the long-press pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btnLong <= 1'b0;
        end else begin
            r_btnLong <= w_longNext;
        end
    end

    assign btnOut     = r_btnOut;
    assign btnPress   = r_btnPress;
    assign btnRelease = r_btnRelease;
    assign btnLong    = r_btnLong;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/debouncer_multi.sv
`default_nettype none
// ============================================================================
// Module      : debouncer_multi
// Description : CHANNELS independent button debouncers with press, release
//               and long-press pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module debouncer_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btnIn,
    output logic [CHANNELS-1:0] btnOut,
    output logic [CHANNELS-1:0] btnPress,
    output logic [CHANNELS-1:0] btnRelease,
    output logic [CHANNELS-1:0] btnLong
);

    // Reject unsupported configurations at elaboration
    if (CHANNELS < 1 || CHANNELS > 32) begin : g_badChannels
        $error("debouncer_multi: CHANNELS must be 1..32");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_badDebounce
        $error("debouncer_multi: DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_badLong
        $error("debouncer_multi: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end
    if (SYNC_STAGES < 2) begin : g_badSync
        $error("debouncer_multi: SYNC_STAGES must be >= 2");
    end

    // One fully independent channel per button
    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_channel (
            .clk        (clk),
            .rst_n      (rst_n),
            .btnIn      (btnIn[i]),
            .btnOut     (btnOut[i]),
            .btnPress   (btnPress[i]),
            .btnRelease (btnRelease[i]),
            .btnLong    (btnLong[i])
        );
    end

endmodule : debouncer_multi
`default_nettype wire

// File: tb/tb_debouncer_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_debouncer_multi
// Description : Directed self-checking bench for debouncer_multi with two
//               channels, 8-cycle debounce, 40-cycle long press.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debouncer_multi;

    logic       clk;
    logic       rst_n;
    logic [1:0] btnIn;
    logic [1:0] btnOut;
    logic [1:0] btnPress;
    logic [1:0] btnRelease;
    logic [1:0] btnLong;

    int total;
    int bad;
    int pressCnt   [2];
    int releaseCnt [2];
    int longCnt    [2];
    int pressBase  [2];
    int releaseBase[2];
    int longBase   [2];

    debouncer_multi #(
        .CHANNELS        (2),
        .DEBOUNCE_CYCLES (8),
        .LONG_CYCLES     (40),
        .SYNC_STAGES     (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btnIn      (btnIn),
        .btnOut     (btnOut),
        .btnPress   (btnPress),
        .btnRelease (btnRelease),
        .btnLong    (btnLong)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running pulse counts per channel
    initial begin
        for (int i = 0; i < 2; i++) begin
            pressCnt[i]   = 0;
            releaseCnt[i] = 0;
            longCnt[i]    = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            pressCnt[i]   <= pressCnt[i]   + int'(btnPress[i]);
            releaseCnt[i] <= releaseCnt[i] + int'(btnRelease[i]);
            longCnt[i]    <= longCnt[i]    + int'(btnLong[i]);
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        total = total + 1;
        if (observed !== expected) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges and settle just after the last one
    task automatic nextEdge(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 2; i++) begin
            pressBase[i]   = pressCnt[i];
            releaseBase[i] = releaseCnt[i];
            longBase[i]    = longCnt[i];
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        btnIn = 2'b00;
        rst_n = 1'b0;

        // Reset state
        nextEdge(3);
        checkVal("rst_out",     32'(btnOut),     32'h0);
        checkVal("rst_press",   32'(btnPress),   32'h0);
        checkVal("rst_release", 32'(btnRelease), 32'h0);
        checkVal("rst_long",    32'(btnLong),    32'h0);
        rst_n = 1'b1;
        nextEdge(5);

        // Clean ch0 press, short hold, release
        snap();
        btnIn[0] = 1'b1;
        nextEdge(9);
        checkVal("t1_out_n9",    32'(btnOut),   32'h0);
        nextEdge(1);
        checkVal("t1_out_n10",   32'(btnOut),   32'h1);
        checkVal("t1_press_n10", 32'(btnPress), 32'h1);
        nextEdge(1);
        checkVal("t1_press_n11", 32'(btnPress), 32'h0);
        nextEdge(9);
        btnIn[0] = 1'b0;
        nextEdge(9);
        checkVal("t1_out_r9",     32'(btnOut),     32'h1);
        checkVal("t1_release_r9", 32'(btnRelease), 32'h0);
        nextEdge(1);
        checkVal("t1_release_r10", 32'(btnRelease), 32'h1);
        checkVal("t1_out_r10",     32'(btnOut),     32'h0);
        nextEdge(50);
        checkVal("t1_press_cnt",   32'(pressCnt[0]   - pressBase[0]),   32'd1);
        checkVal("t1_release_cnt", 32'(releaseCnt[0] - releaseBase[0]), 32'd1);
        checkVal("t1_long_cnt",    32'(longCnt[0]    - longBase[0]),    32'd0);

        // ch0 bounce: 5 high, 1 low, then steady high
        snap();
        btnIn[0] = 1'b1;
        nextEdge(5);
        btnIn[0] = 1'b0;
        nextEdge(1);
        btnIn[0] = 1'b1;
        nextEdge(9);
        checkVal("t2_out_f9",    32'(btnOut),   32'h0);
        nextEdge(1);
        checkVal("t2_out_f10",   32'(btnOut),   32'h1);
        checkVal("t2_press_f10", 32'(btnPress), 32'h1);
        nextEdge(5);
        checkVal("t2_press_cnt",   32'(pressCnt[0]   - pressBase[0]),   32'd1);
        checkVal("t2_release_cnt", 32'(releaseCnt[0] - releaseBase[0]), 32'd0);
        btnIn[0] = 1'b0;
        nextEdge(15);

        // ch1 long hold of 60 cycles
        snap();
        btnIn[1] = 1'b1;
        nextEdge(10);
        checkVal("t3_press_c10", 32'(btnPress), 32'h2);
        nextEdge(39);
        checkVal("t3_long_c49",  32'(btnLong),  32'h0);
        nextEdge(1);
        checkVal("t3_long_c50",  32'(btnLong),  32'h2);
        nextEdge(1);
        checkVal("t3_long_c51",  32'(btnLong),  32'h0);
        nextEdge(9);
        btnIn[1] = 1'b0;
        nextEdge(10);
        checkVal("t3_release_c70", 32'(btnRelease), 32'h2);
        nextEdge(5);
        checkVal("t3_long_cnt",    32'(longCnt[1]    - longBase[1]),    32'd1);
        checkVal("t3_release_cnt", 32'(releaseCnt[1] - releaseBase[1]), 32'd1);

        // Both channels together, reset mid-hold, re-press after reset
        btnIn = 2'b11;
        nextEdge(10);
        checkVal("t4_press_both", 32'(btnPress), 32'h3);
        checkVal("t4_out_both",   32'(btnOut),   32'h3);
        nextEdge(15);
        rst_n = 1'b0;
        #1;
        checkVal("t4_rst_outputs", 32'({btnOut, btnPress, btnRelease, btnLong}), 32'h0);
        nextEdge(3);
        rst_n = 1'b1;
        snap();
        nextEdge(9);
        checkVal("t4_out_g9",   32'(btnOut), 32'h0);
        checkVal("t4_long_pre", 32'((longCnt[0] - longBase[0]) + (longCnt[1] - longBase[1])), 32'd0);
        nextEdge(1);
        checkVal("t4_press_g10", 32'(btnPress), 32'h3);
        nextEdge(39);
        checkVal("t4_long_g49", 32'(btnLong), 32'h0);
        nextEdge(1);
        checkVal("t4_long_g50", 32'(btnLong), 32'h3);
        btnIn = 2'b00;
        nextEdge(15);
        checkVal("t4_release_cnt", 32'((releaseCnt[0] - releaseBase[0]) + (releaseCnt[1] - releaseBase[1])), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_debouncer_multi
`default_nettype wire
